// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM arbiter types and default geometry constants.
package vram_arbiter_pkg;

  localparam int unsigned VRAM_DEPTH  = 1024;
  localparam int unsigned VRAM_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    SCAN = 2'd2,
    ACK  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/vram_scan_fifo.sv
// Two-entry scan word buffer with sof sideband, flush and occupancy output.
module vram_scan_fifo
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W = VRAM_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] push_data_i,
  input  logic              push_sof_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic              sof_o,
  output logic [1:0]        count_o
);

  logic [WORD_W-1:0] data_q [2];
  logic              sof_q  [2];
  logic              rptr_q;
  logic [1:0]        count_q, count_d;
  logic              empty, store, deq, wptr;

  always_comb begin
    empty   = (count_q == 2'd0);
    deq     = ~empty & pop_i & ~flush_i;
    // A word arriving into an empty buffer that is taken at once is never stored.
    store   = push_i & ~(empty & pop_i) & ~flush_i;
    wptr    = rptr_q ^ count_q[0];
    count_d = count_q + {1'b0, store} - {1'b0, deq};
    valid_o = ~flush_i & (~empty | push_i);
    data_o  = '0;
    sof_o   = 1'b0;
    if (!empty) begin
      data_o = data_q[rptr_q];
      sof_o  = sof_q[rptr_q];
    end else if (push_i) begin
      data_o = push_data_i;
      sof_o  = push_sof_i;
    end
  end

  assign count_o = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rptr_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        sof_q[i]  <= 1'b0;
      end
    end else if (flush_i) begin
      count_q <= '0;
      rptr_q  <= 1'b0;
    end else begin
      if (store) begin
        data_q[wptr] <= push_data_i;
        sof_q[wptr]  <= push_sof_i;
      end
      rptr_q  <= rptr_q ^ deq;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between CPU bus and display scan engine.
// Optional starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = VRAM_DEPTH,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned WORD_W       = VRAM_WORD_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [WORD_W-1:0] cpu_rdata,
  input  logic              scan_en,
  output logic              scan_valid,
  input  logic              scan_ready,
  output logic [WORD_W-1:0] scan_data,
  output logic              scan_sof,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              cpu_ack_q, rd_pend_q;
  logic [WORD_W-1:0] rdata_q;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              inflight_q, inflight_sof_q;
  logic [1:0]        fifo_count;
  logic              cpu_elig, scan_elig, cpu_grant, scan_grant, force_scan, rd_done;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q;
  assign force_scan = scan_elig & (starve_q >= STARVE_W'(STARVE_LIMIT));
`else
  assign force_scan = 1'b0;
`endif

  always_comb begin
    cpu_elig   = cpu_req & (state_q != CPU);
    scan_elig  = scan_en & (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
    cpu_grant  = cpu_elig & ~force_scan;
    scan_grant = scan_elig & ~cpu_grant;
    if (cpu_grant)           state_d = CPU;
    else if (scan_grant)     state_d = SCAN;
    else if (state_q == CPU) state_d = ACK;
    else                     state_d = IDLE;

    mem_en    = cpu_grant | scan_grant;
    mem_we    = cpu_grant & cpu_we;
    mem_addr  = cpu_grant ? cpu_addr : (scan_grant ? scan_addr_q : '0);
    mem_wdata = (cpu_grant & cpu_we) ? cpu_wdata : '0;

    if (!scan_en)
      scan_addr_d = '0;
    else if (scan_grant)
      scan_addr_d = (scan_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : scan_addr_q + 1'b1;
    else
      scan_addr_d = scan_addr_q;
  end

  // Memory output is already registered, so read data is forwarded in the ack
  // cycle and rdata_q only holds it until the next read completes.
  assign rd_done   = cpu_ack_q & rd_pend_q;
  assign cpu_rdata = rd_done ? mem_rdata : rdata_q;
  assign cpu_ack   = cpu_ack_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cpu_ack_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rdata_q        <= '0;
      scan_addr_q    <= '0;
      inflight_q     <= 1'b0;
      inflight_sof_q <= 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      starve_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cpu_ack_q      <= cpu_grant;
      rd_pend_q      <= cpu_grant & ~cpu_we;
      if (rd_done) rdata_q <= mem_rdata;
      scan_addr_q    <= scan_addr_d;
      inflight_q     <= scan_grant;
      inflight_sof_q <= (scan_addr_q == '0);
`ifdef VRAM_ARB_STARVE_GUARD_EN
      if (scan_grant)
        starve_q <= '0;
      else if (scan_elig && cpu_grant && starve_q < STARVE_W'(STARVE_LIMIT))
        starve_q <= starve_q + 1'b1;
`endif
    end
  end

  vram_scan_fifo #(.WORD_W(WORD_W)) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .flush_i     (~scan_en),
    .push_i      (inflight_q & scan_en),
    .push_data_i (mem_rdata),
    .push_sof_i  (inflight_sof_q),
    .pop_i       (scan_ready),
    .valid_o     (scan_valid),
    .data_o      (scan_data),
    .sof_o       (scan_sof),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: VRAM model, per-cycle reference model, directed scenarios.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        scan_en, scan_valid, scan_ready, scan_sof;
  logic [15:0] scan_data;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.DEPTH(1024), .ADDR_W(10), .WORD_W(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .scan_en(scan_en), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .scan_data(scan_data), .scan_sof(scan_sof),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // VRAM environment and the bench's own view of its contents.
  logic [15:0] vram   [1024];
  logic [15:0] golden [1024];
  initial for (int i = 0; i < 1024; i++) begin
    vram[i]   = 16'hC000 | 16'(i);
    golden[i] = 16'hC000 | 16'(i);
  end
  always @(posedge clk) if (mem_en) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    else        mem_rdata      <= vram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  bit          m_ack, m_rd, m_pend;
  logic [9:0]  m_rd_addr;
  logic [15:0] m_rdata;
  int          issued, consumed, lost, sof_cnt;
  logic [9:0]  iss_addr, con_addr;

  always @(negedge clk) begin
    bit cpu_g, scan_g, scan_elig;
    int avail;
    if (reset) begin
      chk("rst_cpu_ack", cpu_ack, 0);     chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_scan_valid", scan_valid, 0); chk("rst_scan_data", scan_data, 0);
      chk("rst_scan_sof", scan_sof, 0);   chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);       chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      m_ack = 0; m_rd = 0; m_pend = 0; m_rdata = '0; m_rd_addr = '0;
      issued = 0; consumed = 0; lost = 0; iss_addr = '0; con_addr = '0;
    end else begin
      if (m_ack || m_pend)
        assert (cpu_req) else $error("cpu_req dropped before cpu_ack");
      chk("cpu_ack", cpu_ack, m_ack);
      if (m_ack && m_rd) m_rdata = golden[m_rd_addr];
      chk("cpu_rdata", cpu_rdata, m_rdata);

      if (!scan_en) begin
        issued = 0; consumed = 0; iss_addr = '0; con_addr = '0;
      end
      avail     = issued - consumed;
      chk("scan_valid", scan_valid, scan_en && avail > 0);
      scan_elig = scan_en && avail < 2;
      cpu_g     = cpu_req && !m_ack;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      if (scan_elig && lost >= 4) cpu_g = 0;
      if (scan_elig && !cpu_g) lost = 0;
      else if (scan_elig && cpu_g) lost++;
`endif
      scan_g = scan_elig && !cpu_g;

      if (scan_en && scan_valid && scan_ready && avail > 0) begin
        chk("scan_data", scan_data, golden[con_addr]);
        chk("scan_sof", scan_sof, con_addr == 10'd0);
        if (scan_sof) sof_cnt++;
        consumed++;
        con_addr++;
      end

      chk("mem_en", mem_en, cpu_g || scan_g);
      if (cpu_g) begin
        chk("mem_we_cpu", mem_we, cpu_we);
        chk("mem_addr_cpu", mem_addr, cpu_addr);
        if (cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);
      end else if (scan_g) begin
        chk("mem_we_scan", mem_we, 0);
        chk("mem_addr_scan", mem_addr, iss_addr);
      end

      if (scan_g) begin issued++; iss_addr++; end
      if (cpu_g && cpu_we) golden[cpu_addr] = cpu_wdata;
      m_pend    = cpu_req && !cpu_g && !m_ack;
      m_ack     = cpu_g;
      m_rd      = cpu_g && !cpu_we;
      m_rd_addr = cpu_addr;
    end
  end

  task automatic cpu_op(input logic we, input logic [9:0] a, input logic [15:0] d,
                        input bit drop, output int lat, output logic [15:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; lat = 0; rd = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_ack && lat < 20);
    if (!cpu_ack) begin
      checks++; failures++;
      $display("FAIL cpu_ack_timeout: no ack after %0d cycles, required within 2", lat);
    end
    rd = cpu_rdata;
    @(posedge clk); #1;
    if (drop) cpu_req = 1'b0;
  endtask

  initial begin
    int lat, n, base, g_late;
    logic [15:0] rd;
    logic [9:0]  rd_addrs [6];
    logic [15:0] rd_exp   [6];
    rd_addrs = '{10'd5, 10'd0, 10'd1023, 10'd6, 10'd512, 10'd5};
    rd_exp   = '{16'h1234, 16'hC000, 16'hC3FF, 16'hC006, 16'hC200, 16'h1234};

    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    scan_en = 0; scan_ready = 0; sof_cnt = 0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Scan streaming from address 0.
    scan_en = 1; scan_ready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!scan_valid && n < 10);
    chk("scan_first_lat", n, 2);
    chk("scan_first_data", scan_data, 16'hC000);
    chk("scan_first_sof", scan_sof, 1);
    @(negedge clk);
    chk("scan_second_data", scan_data, 16'hC001);
    chk("scan_second_sof", scan_sof, 0);
    repeat (30) @(posedge clk);
    #1;

    // Consumer stall: buffer fills to two words, then no further grants.
    scan_ready = 0; g_late = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 1 && mem_en) g_late++;
    end
    chk("stall_grants", g_late, 0);
    chk("stall_valid", scan_valid, 1);
    @(posedge clk); #1 scan_ready = 1;
    repeat (20) @(posedge clk);
    #1 scan_en = 0;
    @(negedge clk);
    chk("disable_valid", scan_valid, 0);
    repeat (3) @(posedge clk);
    #1;

    // CPU write then read with scan disabled.
    cpu_op(1'b1, 10'd5, 16'h1234, 1'b1, lat, rd);
    chk("wr_lat", lat, 2);
    cpu_op(1'b0, 10'd5, 16'h0000, 1'b1, lat, rd);
    chk("rd_lat", lat, 2);
    chk("rd_data", rd, 16'h1234);

    // Back-to-back CPU reads while scan runs in the ack cycles.
    scan_en = 1; scan_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      cpu_op(1'b0, rd_addrs[i], 16'h0000, i == 5, lat, rd);
      chk("b2b_lat", lat, 2);
      chk("b2b_data", rd, rd_exp[i]);
    end

    // Restart frame and run past the wrap.
    @(posedge clk); #1 scan_en = 0;
    @(posedge clk); #1 scan_en = 1;
    base = sof_cnt;
    repeat (1030) @(negedge clk);
    #1 chk("wrap_sof_count", sof_cnt - base, 2);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM access controller that shares the 1024-word video memory between the CPU bus interface and the display scan engine. It owns the memory's address/enable/write-enable lines, grants one access per cycle, and runs the scan address generator that walks VRAM in a continuous frame loop. Scan words leave through a 2-entry buffer with a valid/ready handshake. The block sits between the bus-side VRAM decode and the display serializer.

## Interface
- `DEPTH`, 1024, VRAM words; power of two
- `ADDR_W`, 10, log2(DEPTH)
- `WORD_W`, 16, data width
- `STARVE_LIMIT`, 4, consecutive lost scan arbitrations before a forced scan grant (guard build only)

- `clk` in 1: single clock; all logic on the rising edge
- `reset` in 1: asynchronous, active-high
- `cpu_req` in 1: CPU access request; held until `cpu_ack`
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req`
- `cpu_addr` in ADDR_W: VRAM-relative word address
- `cpu_wdata` in WORD_W: write data
- `cpu_ack` out 1: one-cycle completion pulse
- `cpu_rdata` out WORD_W: read data, valid with `cpu_ack` on reads
- `scan_en` in 1: scan engine enable
- `scan_valid` out 1: buffer head valid
- `scan_ready` in 1: consumer accepts head when `scan_valid & scan_ready`
- `scan_data` out WORD_W: buffer head word
- `scan_sof` out 1: head word came from address 0
- `mem_en` out 1: memory access this cycle
- `mem_we` out 1: memory write this cycle
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out WORD_W: memory write data
- `mem_rdata` in WORD_W: synchronous read data; valid one cycle after `mem_en & ~mem_we`

## Operation
- FSM states:
  - `IDLE`: no access.
  - `CPU`: CPU granted this cycle.
  - `SCAN`: scan granted this cycle.
  - `ACK`: cycle after a CPU grant; `cpu_ack` high; CPU is not eligible for a grant in this cycle.
- Scan eligibility: `scan_en` & (buffer occupancy + in-flight scan reads < 2).
- Arbitration each cycle: CPU eligible (`cpu_req` & state ≠ `CPU`/`ACK`) wins. Otherwise scan wins if eligible. Otherwise `IDLE`.
- From `ACK` the next state is `SCAN` or `IDLE` only. A scan grant may therefore fill the ACK cycle.
- CPU write: `mem_we=1` in the grant cycle; `cpu_ack` the next cycle.
- CPU read: `cpu_rdata` is registered from `mem_rdata` and presented with `cpu_ack`. It holds its value until the next CPU read completes.
- Scan read: `mem_addr` = scan counter. The counter increments on grant and wraps from DEPTH-1 to 0. A returning word is pushed to the buffer with sof = (its address == 0).
- Buffer: 2-entry FIFO. Simultaneous push and pop when full is legal, because the in-flight accounting guarantees a free slot.
- `scan_en` low: no new scan grants. The counter resets to 0, the buffer is flushed, and any in-flight scan word is discarded. The frame always restarts at address 0 on re-enable.
- Reset: all outputs 0, state `IDLE`, counter 0, buffer empty, starve counter 0.

## Timing
- CPU: request sampled at cycle T, grant at T (mem_* driven combinationally from the grant), `cpu_ack` at T+1. Sustained throughput is one CPU access per 2 cycles.
- Scan: grant at T, word pushed at T+1, `scan_valid` at T+1 if the buffer was empty. Sustained rate is 1 word/cycle with no CPU traffic.
- `reset` asserted mid-access: the access is abandoned and no `cpu_ack` is issued. The requester re-presents after reset.
- `cpu_req` dropped before ack: illegal. Behaviour is undefined and asserted against in the bench.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined: a counter increments on each cycle where scan is eligible but the CPU is granted. It clears on any scan grant. At `STARVE_LIMIT` the next eligible cycle grants scan even if the CPU is eligible; the CPU is granted the following cycle.
- Undefined: strict CPU priority and no counter. Scan is guaranteed progress only through `ACK` cycles.

## Structure
- Shared package holds the state enum (`IDLE`, `CPU`, `SCAN`, `ACK`) and the default `WORD_W`/`DEPTH` constants, matching the existing VRAM range header.
- One sub-module, `vram_scan_fifo`, implements the 2-entry buffer with sof sideband, flush, and occupancy output. Arbitration, FSM and scan counter stay in the top module.

## Test plan
- Reset then idle: every output 0; `scan_en=1` with `scan_ready=1` → words from addresses 0,1,2… stream 1/cycle, `scan_sof` only on address 0.
- CPU write 0x1234 to addr 5, then read addr 5 → each `cpu_ack` arrives one cycle after its grant, and the read returns `cpu_rdata=0x1234`.
- Back-to-back CPU requests with scan enabled → ACK cycles are scan grants. The CPU gets one access per 2 cycles and scan order stays gap-free.
- `scan_ready=0` for 10 cycles → at most 2 words buffered and no scan grants issued. When released, the words resume in order with none lost or duplicated.
- Scan reaches address 1023 then wraps → next word is address 0 with `scan_sof=1`. Dropping `scan_en` mid-frame and re-enabling restarts at 0.
- Guard build, CPU requests continuously with `STARVE_LIMIT=4` → scan is granted after 4 lost arbitrations, and the CPU is granted the next cycle. Without the guard, scan grants occur only in ACK cycles.
